// File: rtl/mult_share_if.sv
// mult_share_if: requester, response and multiplier signals of mult_share_arbiter
// slave:  arbiter side (requests and multiplier results in; acks, responses, multiplier controls out)
// master: environment side (requesters plus the multiplier)
interface mult_share_if #(parameter int WIDTH = 4);
  logic req0, req1, ack0, ack1, busy;
  logic [WIDTH-1:0] md0, mr0, md1, mr1, m_md, m_mr;
  logic resp_valid, resp_id, resp_ovf, resp_zero, resp_err;
  logic [2*WIDTH-1:0] resp_pp, m_pp;
  logic m_init, m_rst, m_done, m_ovf, m_zero;
  modport slave (
    input  req0, req1, md0, mr0, md1, mr1, m_pp, m_done, m_ovf, m_zero,
    output ack0, ack1, busy, resp_valid, resp_id, resp_pp, resp_ovf, resp_zero, resp_err,
           m_md, m_mr, m_init, m_rst
  );
  modport master (
    output req0, req1, md0, mr0, md1, mr1, m_pp, m_done, m_ovf, m_zero,
    input  ack0, ack1, busy, resp_valid, resp_id, resp_pp, resp_ovf, resp_zero, resp_err,
           m_md, m_mr, m_init, m_rst
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one sequential multiplier between two requesters
// clk: rising-edge clock; rst: synchronous reset, active-low
// bus (slave): req/md/mr per requester, ack pulses, tagged response, multiplier md/mr/init/rst/pp/done/ovf/zero
module mult_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT = 31
) (
  input logic clk,
  input logic rst,
  mult_share_if.slave bus
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RESP} state_t;
  state_t state, nxt_state;
  logic last_grant, win1, grant, cap;
  logic nxt_busy, nxt_m_rst, nxt_m_init, nxt_ack0, nxt_ack1, nxt_resp_valid;
  logic [IW-1:0] init_cnt;
  logic [TW-1:0] timer;
  // with both requests up, the one not served last time wins
  assign win1 = bus.req1 & (~bus.req0 | ~last_grant);
  assign grant = state == IDLE && (bus.req0 || bus.req1);
  assign cap = state == WAIT && nxt_state == RESP;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      init_cnt <= '0;
      timer <= '0;
      bus.busy <= 1'b0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.m_rst <= 1'b1;
      bus.m_init <= 1'b0;
      bus.m_md <= '0;
      bus.m_mr <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id <= 1'b0;
      bus.resp_pp <= '0;
      bus.resp_ovf <= 1'b0;
      bus.resp_zero <= 1'b0;
      bus.resp_err <= 1'b0;
    end else begin
      state <= nxt_state;
      bus.busy <= nxt_busy;
      bus.ack0 <= nxt_ack0;
      bus.ack1 <= nxt_ack1;
      bus.m_rst <= nxt_m_rst;
      bus.m_init <= nxt_m_init;
      bus.resp_valid <= nxt_resp_valid;
      init_cnt <= state == CLEAR ? I_LAST : state == START ? init_cnt - 1'b1 : init_cnt;
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (grant) begin
        last_grant <= win1;
        bus.m_md <= win1 ? bus.md1 : bus.md0;
        bus.m_mr <= win1 ? bus.mr1 : bus.mr0;
      end
      // done takes priority; a timeout reports zeros with err set
      if (cap) begin
        bus.resp_id <= last_grant;
        bus.resp_pp <= bus.m_done ? bus.m_pp : '0;
        bus.resp_ovf <= bus.m_done & bus.m_ovf;
        bus.resp_zero <= bus.m_done & bus.m_zero;
        bus.resp_err <= ~bus.m_done;
      end
    end
  end
  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    nxt_state = grant ? CLEAR : IDLE;
      CLEAR:   nxt_state = START;
      START:   nxt_state = init_cnt == '0 ? WAIT : START;
      WAIT:    nxt_state = bus.m_done || timer == T_LAST ? RESP : WAIT;
      RESP:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end
  always_comb begin
    nxt_busy = nxt_state != IDLE;
    nxt_m_rst = nxt_state == CLEAR;
    nxt_m_init = nxt_state == START;
    nxt_resp_valid = nxt_state == RESP;
    nxt_ack0 = grant & ~win1;
    nxt_ack1 = grant & win1;
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: table, directed and random checks of mult_share_arbiter against a behavioural model
module tb_mult_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic pred_last = 1'b1;
  logic never_done = 1'b0;
  logic [7:0] mpp = 8'h00;
  logic mdone = 1'b0, movf = 1'b0, mzero = 1'b0;
  int mcnt = 0;
  logic [7:0] prod;
  mult_share_if #(.WIDTH(4)) bus ();
  mult_share_arbiter #(.WIDTH(4), .INIT_CYCLES(2), .TIMEOUT(31)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign prod = {4'b0, bus.m_md} * {4'b0, bus.m_mr};
  assign bus.m_pp = mpp;
  assign bus.m_done = mdone;
  assign bus.m_ovf = movf;
  assign bus.m_zero = mzero;
  always @(posedge clk) begin
    if (bus.m_rst) begin
      mdone <= 1'b0;
      mcnt <= 0;
      mpp <= 8'hA5;
      movf <= 1'b1;
      mzero <= 1'b1;
    end else if (bus.m_init) begin
      mdone <= 1'b0;
      mcnt <= 4;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !never_done) begin
        mdone <= 1'b1;
        mpp <= prod;
        movf <= prod[7];
        mzero <= prod == 8'd0;
      end
    end
  end
  typedef struct {
    logic r0, r1;
    logic [3:0] a0, b0, a1, b1;
    int id, pp;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pred_last = 1'b1;
  endtask
  task automatic do_op(input logic r0, r1, input logic [3:0] a0, b0, a1, b1,
                       output int id, pp, z, o, e, lat);
    int aw;
    @(negedge clk);
    bus.req0 = r0; bus.req1 = r1;
    bus.md0 = a0; bus.mr0 = b0; bus.md1 = a1; bus.mr1 = b1;
    aw = -1;
    for (int i = 0; i < 20 && aw < 0; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) aw = int'(bus.ack1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.md0 = ~a0; bus.md1 = ~a1;
    id = -1; pp = -1; z = -1; o = -1; e = -1; lat = 0;
    if (aw < 0) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    chk("m_md", bus.m_md, aw == 1 ? a1 : a0);
    chk("m_mr", bus.m_mr, aw == 1 ? b1 : b0);
    for (int i = 0; i < 100 && id < 0; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) chk("ack_pulse", int'(bus.ack0 | bus.ack1), 0);
      if (bus.resp_valid) begin
        id = bus.resp_id; pp = bus.resp_pp; z = bus.resp_zero; o = bus.resp_ovf; e = bus.resp_err;
      end
    end
    if (id < 0) chk("resp_timeout", 0, 1);
    else chk("ack_id", aw, id);
  endtask
  task automatic check_op(input logic r0, r1, input logic [3:0] a0, b0, a1, b1, input int xid);
    int id, pp, z, o, e, lat, xpp;
    do_op(r0, r1, a0, b0, a1, b1, id, pp, z, o, e, lat);
    xpp = xid == 1 ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
    chk("id", id, xid);
    chk("pp", pp, xpp);
    chk("zero", z, int'(xpp == 0));
    chk("ovf", o, int'(xpp >= 128));
    chk("err", e, 0);
    pred_last = xid[0];
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int id, pp, z, o, e, lat, nresp;
    int ids[$];
    int pps[$];
    logic r0, r1, w;
    logic [3:0] a0, b0, a1, b1;
    tbl[0] = '{1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0, 0, 9};
    tbl[1] = '{1'b1, 1'b1, 4'd6, 4'd4, 4'd6, 4'd6, 1, 36};
    tbl[2] = '{1'b1, 1'b1, 4'd6, 4'd4, 4'd6, 4'd6, 0, 24};
    tbl[3] = '{1'b1, 1'b0, 4'd0, 4'd7, 4'd1, 4'd1, 0, 0};
    tbl[4] = '{1'b0, 1'b1, 4'd1, 4'd1, 4'd15, 4'd15, 1, 225};
    tbl[5] = '{1'b1, 1'b1, 4'd2, 4'd5, 4'd7, 4'd3, 0, 10};
    tbl[6] = '{1'b1, 1'b1, 4'd2, 4'd5, 4'd7, 4'd3, 1, 21};
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.md0 = '0; bus.mr0 = '0; bus.md1 = '0; bus.mr1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_rst", bus.m_rst, 1);
    chk("rst_ack", int'(bus.ack0 | bus.ack1), 0);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_m_md", bus.m_md, 0);
    chk("rst_pp", bus.resp_pp, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_m_rst", bus.m_rst, 0);
    chk("idle_busy", bus.busy, 0);
    foreach (tbl[i]) begin
      check_op(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].id);
      chk("tbl_pp", tbl[i].id == 1 ? int'(tbl[i].a1) * int'(tbl[i].b1) : int'(tbl[i].a0) * int'(tbl[i].b0), tbl[i].pp);
    end
    do_reset();
    @(negedge clk);
    bus.md0 = 4'd6; bus.mr0 = 4'd4; bus.md1 = 4'd6; bus.mr1 = 4'd6;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    nresp = 0;
    for (int i = 0; i < 200 && nresp < 2; i++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) chk("dual_ack", 1, 0);
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (bus.resp_valid) begin
        ids.push_back(int'(bus.resp_id));
        pps.push_back(int'(bus.resp_pp));
        nresp++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("pair_count", nresp, 2);
    if (nresp == 2) begin
      chk("pair_id0", ids[0], 0);
      chk("pair_pp0", pps[0], 24);
      chk("pair_id1", ids[1], 1);
      chk("pair_pp1", pps[1], 36);
    end
    do_reset();
    ids.delete();
    pps.delete();
    @(negedge clk);
    bus.md0 = 4'd2; bus.mr0 = 4'd3; bus.md1 = 4'd5; bus.mr1 = 4'd3;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 400 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ids.push_back(int'(bus.resp_id));
        pps.push_back(int'(bus.resp_pp));
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("rr_count", ids.size(), 4);
    foreach (ids[i]) begin
      chk("rr_id", ids[i], i % 2);
      chk("rr_pp", pps[i], i % 2 == 1 ? 15 : 6);
    end
    do_reset();
    never_done = 1'b1;
    do_op(1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0, id, pp, z, o, e, lat);
    chk("to_id", id, 0);
    chk("to_err", e, 1);
    chk("to_pp", pp, 0);
    chk("to_ovf", o, 0);
    chk("to_zero", z, 0);
    chk("to_latency", lat, 1 + 2 + 31);
    never_done = 1'b0;
    pred_last = 1'b0;
    check_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 4'd5, 1);
    never_done = 1'b1;
    @(negedge clk);
    bus.req1 = 1'b1; bus.md1 = 4'd7; bus.mr1 = 4'd7;
    w = 1'b0;
    for (int i = 0; i < 20 && !w; i++) begin
      @(negedge clk);
      w = bus.ack1;
    end
    bus.req1 = 1'b0;
    chk("wr_ack", w, 1);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pred_last = 1'b1;
    chk("wr_busy", bus.busy, 0);
    chk("wr_m_rst", bus.m_rst, 1);
    chk("wr_valid", bus.resp_valid, 0);
    chk("wr_m_init", bus.m_init, 0);
    chk("wr_err", bus.resp_err, 0);
    never_done = 1'b0;
    nresp = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    chk("wr_no_resp", nresp, 0);
    check_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd7, 1);
    for (int k = 0; k < 20; k++) begin
      {r1, r0} = 2'($urandom_range(1, 3));
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      w = (r0 && r1) ? ~pred_last : r1;
      check_op(r0, r1, a0, b0, a1, b1, int'(w));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
